// File: rtl/ima_pixel_scanner.sv
// ima_pixel_scanner: raster-scan frame RAM reader feeding a valid/ready pixel stream
module ima_pixel_scanner #(
  parameter int IMG_HEIGHT = 320,
  parameter int IMG_WIDTH = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [8:0]        mask_row_offset_in,
  input  logic [7:0]        mask_col_offset_in,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [11:0]       ram_rdata,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic [11:0]       image_pixel,
  output logic [8:0]        pixel_row,
  output logic [7:0]        pixel_col,
  output logic [8:0]        mask_row_offset,
  output logic [7:0]        mask_col_offset,
  output logic              busy,
  output logic              done
);
  localparam logic [8:0] ROW_LAST = 9'(IMG_HEIGHT - 1);
  localparam logic [7:0] COL_LAST = 8'(IMG_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [8:0] row, rd_row;
  logic [7:0] col, rd_col;
  logic [1:0] outst, fcnt;
  logic rd_q, wp, rp;
  logic [28:0] fifo [2];
  logic accept, out_free, from_fifo, from_ram, push, last_rd;
  assign ram_rd_en = state == RUN && outst < 2'd3;
  assign busy      = state == RUN || state == DRAIN;
  assign done      = state == DONE;
  assign accept    = pixel_valid && pixel_ready;
  assign out_free  = !pixel_valid || pixel_ready;
  assign from_fifo = out_free && fcnt != 2'd0;
  assign from_ram  = out_free && fcnt == 2'd0 && rd_q;
  assign push      = rd_q && !from_ram;
  assign last_rd   = ram_rd_en && row == ROW_LAST && col == COL_LAST;
  // next state: DRAIN ends when the only outstanding beat is accepted
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (start ? RUN : IDLE) :
               state == RUN   ? (last_rd ? DRAIN : RUN) :
               state == DRAIN ? ((accept && outst == 2'd1) ? DONE : DRAIN) : IDLE;
  end
  // state, raster counters, offset latch and outstanding-read count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      ram_addr <= '0;
      mask_row_offset <= '0;
      mask_col_offset <= '0;
      outst <= '0;
    end else begin
      state <= state_nx;
      outst <= outst + {1'b0, ram_rd_en} - {1'b0, accept};
      if (state == IDLE && start) begin
        row <= '0;
        col <= '0;
        ram_addr <= '0;
        mask_row_offset <= mask_row_offset_in;
        mask_col_offset <= mask_col_offset_in;
      end else if (ram_rd_en) begin
        col <= col == COL_LAST ? 8'd0 : col + 8'd1;
        row <= col == COL_LAST ? row + 9'd1 : row;
        ram_addr <= ram_addr + 1'b1;
      end
    end
  end
  // tag each read with its coordinates so they line up with the returning data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= 1'b0;
      rd_row <= '0;
      rd_col <= '0;
    end else begin
      rd_q <= ram_rd_en;
      rd_row <= row;
      rd_col <= col;
    end
  end
  // skid FIFO and output register; FIFO head has priority over fresh RAM data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      fcnt <= '0;
      pixel_valid <= 1'b0;
      image_pixel <= '0;
      pixel_row <= '0;
      pixel_col <= '0;
    end else begin
      if (push) fifo[wp] <= {ram_rdata, rd_row, rd_col};
      if (push) wp <= !wp;
      if (from_fifo) rp <= !rp;
      fcnt <= fcnt + {1'b0, push} - {1'b0, from_fifo};
      if (out_free) pixel_valid <= from_fifo || from_ram;
      if (from_fifo) {image_pixel, pixel_row, pixel_col} <= fifo[rp];
      else if (from_ram) {image_pixel, pixel_row, pixel_col} <= {ram_rdata, rd_row, rd_col};
    end
  end
endmodule
